memory_stage: RTL and testbench

- Consumer end of the execute latch in the 5-stage pipeline.
- Takes the registered EX/MEM outputs and drives the data-cache request with the dhit handshake, stalling upstream latches until dhit returns.
- Resolves branches and jumps into a PC redirect and a flush.
- Registers the MEM/WB values (write-back select, data, enable, halt) for the register file.

---
 rtl/memory_stage_if.sv | 20 ++
 rtl/memory_stage.sv | 122 ++++++++++++
 tb/tb_memory_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Data-cache request bus between the MEM stage (master) and the data cache (slave).
// The request holds while dhit is low, and completes in the cycle dhit is high.
interface memory_stage_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/memory_stage.sv
// MEM stage: drives the dcache, resolves branches and jumps, and registers MEM/WB (WB lands one edge after completion).
// Backpressure: stall holds the upstream latches while dhit is pending, and permanently once halted.
module memory_stage #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [31:0]          ex_pc_plus_4,
    input  logic [31:0]          ex_baddr,
    input  logic [31:0]          ex_jaddr,
    input  logic                 ex_zero,
    input  logic                 ex_Branch,
    input  logic                 ex_bne,
    input  logic                 ex_Jump,
    input  logic                 ex_JAL,
    input  logic                 ex_regWEN,
    input  logic                 ex_MemtoReg,
    input  logic                 ex_dREN,
    input  logic                 ex_dWEN,
    input  logic                 ex_halt,
    input  logic [4:0]           ex_wsel,
    input  logic [31:0]          ex_portout,
    input  logic [31:0]          ex_rdat2,
    memory_stage_if.master       dmem,
    output logic                 stall,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic                 flush,
    output logic                 wb_regWEN,
    output logic [4:0]           wb_wsel,
    output logic [31:0]          wb_wdat,
    output logic                 wb_halt,
    output logic                 mem_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEMWAIT = 2'd1;
    localparam logic [1:0] S_HALTED  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             stall_raw;
    logic             mem_op;
    logic             active;
    logic             taken;
    logic             wait_hit;

    assign mem_op = ex_dREN | ex_dWEN;

    // A halt riding on a memory op only takes effect once dhit completes the access.
    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op && !dmem.dhit) begin
                    stall_raw = 1'b1;
                    state_nxt = S_MEMWAIT;
                end else if (ex_halt) begin
                    state_nxt = S_HALTED;
                end
            end
            S_MEMWAIT: begin
                if (dmem.dhit) begin
                    state_nxt = ex_halt ? S_HALTED : S_IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            S_HALTED: stall_raw = 1'b1;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Reset gates the combinational outputs so nothing reaches the cache or PC while nRST is low.
    assign active         = nRST && (state != S_HALTED);
    assign dmem.dmemREN   = active & ex_dREN;
    assign dmem.dmemWEN   = active & ex_dWEN & ~ex_dREN;
    assign dmem.dmemaddr  = ex_portout;
    assign dmem.dmemstore = ex_rdat2;
    assign stall          = nRST & stall_raw;

    assign taken       = ex_Branch & (ex_zero ^ ex_bne);
    assign redirect    = active & ~stall_raw & (ex_Jump | taken);
    assign redirect_pc = ex_Jump ? ex_jaddr : ex_baddr;
    assign flush       = redirect;

    assign wait_hit = (WAIT_LIMIT != 0) && (state == S_MEMWAIT) && (wait_cnt == CNT_W'(WAIT_LIMIT));
    assign mem_err  = err_q | wait_hit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            wb_regWEN <= 1'b0;
            wb_wsel   <= '0;
            wb_wdat   <= '0;
            wb_halt   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_MEMWAIT && !dmem.dhit) begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            err_q <= err_q | wait_hit;
            if (state != S_HALTED && state_nxt == S_HALTED) wb_halt <= 1'b1;
            if (stall_raw) begin
                wb_regWEN <= 1'b0;
            end else begin
                wb_regWEN <= ex_regWEN;
                wb_wsel   <= ex_wsel;
                wb_wdat   <= ex_JAL ? ex_pc_plus_4 : (ex_MemtoReg ? dmem.dmemload : ex_portout);
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: reset, directed vector table, hand-written multi-cycle sequences,
// and random instructions with random dhit latency against a behavioural model.
module tb_memory_stage;

    logic        CLK;
    logic        nRST;
    logic [31:0] ex_pc_plus_4, ex_baddr, ex_jaddr, ex_portout, ex_rdat2;
    logic        ex_zero, ex_Branch, ex_bne, ex_Jump, ex_JAL, ex_regWEN, ex_MemtoReg;
    logic        ex_dREN, ex_dWEN, ex_halt;
    logic [4:0]  ex_wsel;
    logic        stall, redirect, flush, wb_regWEN, wb_halt, mem_err;
    logic [31:0] redirect_pc, wb_wdat;
    logic [4:0]  wb_wsel;

    int checks = 0;
    int errors = 0;

    memory_stage_if dmem_bus ();

    memory_stage #(.WAIT_LIMIT(5), .CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .ex_pc_plus_4(ex_pc_plus_4), .ex_baddr(ex_baddr), .ex_jaddr(ex_jaddr),
        .ex_zero(ex_zero), .ex_Branch(ex_Branch), .ex_bne(ex_bne), .ex_Jump(ex_Jump),
        .ex_JAL(ex_JAL), .ex_regWEN(ex_regWEN), .ex_MemtoReg(ex_MemtoReg),
        .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_halt(ex_halt), .ex_wsel(ex_wsel),
        .ex_portout(ex_portout), .ex_rdat2(ex_rdat2),
        .dmem(dmem_bus.master),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .wb_regWEN(wb_regWEN), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .wb_halt(wb_halt), .mem_err(mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc4, baddr, jaddr, portout, rdat2, load;
        logic [4:0]  wsel;
        logic        zero, br, bne, jmp, jal, regwen, m2r, dren, dwen;
        logic        e_redir;
        logic [31:0] e_pc;
        logic        e_ren, e_wen, e_wbwen;
        logic [31:0] e_wdat;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ex_pc_plus_4 = '0; ex_baddr = '0; ex_jaddr = '0; ex_portout = '0; ex_rdat2 = '0;
        ex_zero = 0; ex_Branch = 0; ex_bne = 0; ex_Jump = 0; ex_JAL = 0; ex_regWEN = 0;
        ex_MemtoReg = 0; ex_dREN = 0; ex_dWEN = 0; ex_halt = 0; ex_wsel = '0;
        dmem_bus.dhit = 1'b0; dmem_bus.dmemload = '0;
    endtask

    logic [4:0]  last_wsel;
    logic [31:0] last_wdat;
    logic [31:0] hit_load;
    logic        exp_redir;
    int          d;

    initial begin
        // pc4 baddr jaddr portout rdat2 load wsel | zero br bne jmp jal regwen m2r dren dwen | redir pc ren wen wbwen wdat
        tbl[0] = '{32'h4,  32'h100, 32'h0,   32'h0,    32'h0,    32'h0,        5'd0,  1,1,0,0,0,0,0,0,0, 1, 32'h100, 0,0,0, 32'h0};
        tbl[1] = '{32'h4,  32'h100, 32'h0,   32'h0,    32'h0,    32'h0,        5'd0,  1,1,1,0,0,0,0,0,0, 0, 32'h0,   0,0,0, 32'h0};
        tbl[2] = '{32'h8,  32'h180, 32'h0,   32'h7,    32'h0,    32'h0,        5'd2,  0,1,1,0,0,0,0,0,0, 1, 32'h180, 0,0,0, 32'h7};
        tbl[3] = '{32'h8,  32'h180, 32'h0,   32'h0,    32'h0,    32'h0,        5'd0,  0,1,0,0,0,0,0,0,0, 0, 32'h0,   0,0,0, 32'h0};
        tbl[4] = '{32'h14, 32'h0,   32'h200, 32'h55,   32'h0,    32'h0,        5'd31, 0,0,0,1,1,1,0,0,0, 1, 32'h200, 0,0,1, 32'h14};
        tbl[5] = '{32'h18, 32'h300, 32'h240, 32'h0,    32'h0,    32'h0,        5'd0,  1,1,0,1,0,0,0,0,0, 1, 32'h240, 0,0,0, 32'h0};
        tbl[6] = '{32'h1c, 32'h0,   32'h0,   32'h80,   32'h1234, 32'h0,        5'd0,  0,0,0,0,0,0,0,0,1, 0, 32'h0,   0,1,0, 32'h80};
        tbl[7] = '{32'h20, 32'h0,   32'h0,   32'h44,   32'h0,    32'hCAFEF00D, 5'd9,  0,0,0,0,0,1,1,1,0, 0, 32'h0,   1,0,1, 32'hCAFEF00D};
        tbl[8] = '{32'h24, 32'h0,   32'h0,   32'h48,   32'h99,   32'h11,       5'd4,  0,0,0,0,0,0,0,1,1, 0, 32'h0,   1,0,0, 32'h48};
        tbl[9] = '{32'h28, 32'h0,   32'h0,   32'hA5A5, 32'h0,    32'h0,        5'd3,  0,0,0,0,0,1,0,0,0, 0, 32'h0,   0,0,1, 32'hA5A5};

        // Reset: outputs forced low even with active-looking inputs.
        nRST = 1'b1;
        clear_inputs();
        #2 nRST = 1'b0;
        ex_dREN = 1; ex_dWEN = 1; ex_Jump = 1; ex_regWEN = 1; ex_wsel = 5'd7;
        #1;
        check("rst_dmemREN", dmem_bus.dmemREN, 1'b0);
        check("rst_dmemWEN", dmem_bus.dmemWEN, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_redirect", redirect, 1'b0);
        check("rst_flush", flush, 1'b0);
        tick();
        check("rst_wb_regWEN", wb_regWEN, 1'b0);
        check("rst_wb_wsel", wb_wsel, 5'd0);
        check("rst_wb_wdat", wb_wdat, 32'h0);
        check("rst_wb_halt", wb_halt, 1'b0);
        check("rst_mem_err", mem_err, 1'b0);
        clear_inputs();
        nRST = 1'b1;
        tick();

        // Load with four-cycle dhit latency.
        ex_dREN = 1; ex_portout = 32'h40; ex_MemtoReg = 1; ex_regWEN = 1; ex_wsel = 5'd8;
        for (int c = 0; c <= 4; c++) begin
            dmem_bus.dhit = (c == 4);
            dmem_bus.dmemload = (c == 4) ? 32'hDEADBEEF : 32'h0BAD0BAD;
            #1;
            check("ld_stall", stall, (c < 4));
            check("ld_addr", dmem_bus.dmemaddr, 32'h40);
            check("ld_ren", dmem_bus.dmemREN, 1'b1);
            tick();
            if (c < 4) check("ld_bubble", wb_regWEN, 1'b0);
        end
        check("ld_wb_regWEN", wb_regWEN, 1'b1);
        check("ld_wb_wsel", wb_wsel, 5'd8);
        check("ld_wb_wdat", wb_wdat, 32'hDEADBEEF);
        clear_inputs();
        tick();
        check("ld_wb_once", wb_regWEN, 1'b0);

        // Single-cycle directed vectors; any memory op hits immediately.
        foreach (tbl[i]) begin
            ex_pc_plus_4 = tbl[i].pc4; ex_baddr = tbl[i].baddr; ex_jaddr = tbl[i].jaddr;
            ex_portout = tbl[i].portout; ex_rdat2 = tbl[i].rdat2; ex_wsel = tbl[i].wsel;
            ex_zero = tbl[i].zero; ex_Branch = tbl[i].br; ex_bne = tbl[i].bne;
            ex_Jump = tbl[i].jmp; ex_JAL = tbl[i].jal; ex_regWEN = tbl[i].regwen;
            ex_MemtoReg = tbl[i].m2r; ex_dREN = tbl[i].dren; ex_dWEN = tbl[i].dwen;
            dmem_bus.dhit = 1'b1; dmem_bus.dmemload = tbl[i].load;
            #1;
            check($sformatf("vec%0d_stall", i), stall, 1'b0);
            check($sformatf("vec%0d_redirect", i), redirect, tbl[i].e_redir);
            check($sformatf("vec%0d_flush", i), flush, tbl[i].e_redir);
            if (tbl[i].e_redir) check($sformatf("vec%0d_redirect_pc", i), redirect_pc, tbl[i].e_pc);
            check($sformatf("vec%0d_dmemREN", i), dmem_bus.dmemREN, tbl[i].e_ren);
            check($sformatf("vec%0d_dmemWEN", i), dmem_bus.dmemWEN, tbl[i].e_wen);
            check($sformatf("vec%0d_dmemaddr", i), dmem_bus.dmemaddr, tbl[i].portout);
            check($sformatf("vec%0d_dmemstore", i), dmem_bus.dmemstore, tbl[i].rdat2);
            tick();
            check($sformatf("vec%0d_wb_regWEN", i), wb_regWEN, tbl[i].e_wbwen);
            check($sformatf("vec%0d_wb_wsel", i), wb_wsel, tbl[i].wsel);
            check($sformatf("vec%0d_wb_wdat", i), wb_wdat, tbl[i].e_wdat);
        end
        last_wsel = tbl[9].wsel;
        last_wdat = tbl[9].e_wdat;

        // Random instructions, random dhit latency for memory ops.
        for (int n = 0; n < 150; n++) begin
            ex_pc_plus_4 = $urandom; ex_baddr = $urandom; ex_jaddr = $urandom;
            ex_portout = $urandom; ex_rdat2 = $urandom; ex_wsel = 5'($urandom);
            ex_zero = 1'($urandom); ex_Branch = 1'($urandom); ex_bne = 1'($urandom);
            ex_Jump = ($urandom_range(0, 3) == 0); ex_JAL = ex_Jump & 1'($urandom);
            ex_regWEN = 1'($urandom); ex_MemtoReg = 1'($urandom);
            ex_dREN = ($urandom_range(0, 3) == 0); ex_dWEN = ($urandom_range(0, 3) == 0);
            d = (ex_dREN || ex_dWEN) ? int'($urandom_range(0, 3)) : 0;
            hit_load = $urandom;
            for (int c = 0; c <= d; c++) begin
                dmem_bus.dhit = (c == d);
                dmem_bus.dmemload = (c == d) ? hit_load : $urandom;
                #1;
                exp_redir = (c == d) && (ex_Jump || (ex_Branch && (ex_zero != ex_bne)));
                check("rnd_stall", stall, (c < d));
                check("rnd_redirect", redirect, exp_redir);
                if (exp_redir) check("rnd_redirect_pc", redirect_pc, ex_Jump ? ex_jaddr : ex_baddr);
                check("rnd_dmemREN", dmem_bus.dmemREN, ex_dREN);
                check("rnd_dmemWEN", dmem_bus.dmemWEN, ex_dWEN && !ex_dREN);
                check("rnd_dmemaddr", dmem_bus.dmemaddr, ex_portout);
                tick();
                if (c < d) begin
                    check("rnd_bubble", wb_regWEN, 1'b0);
                    check("rnd_hold_wsel", wb_wsel, last_wsel);
                    check("rnd_hold_wdat", wb_wdat, last_wdat);
                end
            end
            last_wsel = ex_wsel;
            last_wdat = ex_JAL ? ex_pc_plus_4 : (ex_MemtoReg ? hit_load : ex_portout);
            check("rnd_wb_regWEN", wb_regWEN, ex_regWEN);
            check("rnd_wb_wsel", wb_wsel, last_wsel);
            check("rnd_wb_wdat", wb_wdat, last_wdat);
        end
        check("rnd_no_mem_err", mem_err, 1'b0);

        // Timeout: mem_err rises once the request has spent 5 full cycles in MEMWAIT, then sticks.
        clear_inputs();
        ex_dREN = 1; ex_portout = 32'h300;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("to_mem_err_e%0d", e), mem_err, (e >= 6));
            check("to_stall", stall, 1'b1);
        end
        dmem_bus.dhit = 1'b1;
        #1;
        check("to_release_stall", stall, 1'b0);
        tick();
        clear_inputs();
        tick();
        check("to_sticky1", mem_err, 1'b1);
        tick();
        check("to_sticky2", mem_err, 1'b1);

        // Asynchronous reset in the middle of a pending load.
        ex_dREN = 1; ex_regWEN = 1; ex_wsel = 5'd5; ex_portout = 32'h60;
        tick(); tick(); tick();
        #2 nRST = 1'b0;
        #1;
        check("mr_dmemREN", dmem_bus.dmemREN, 1'b0);
        check("mr_stall", stall, 1'b0);
        check("mr_wb_regWEN", wb_regWEN, 1'b0);
        check("mr_wb_wsel", wb_wsel, 5'd0);
        check("mr_wb_wdat", wb_wdat, 32'h0);
        check("mr_mem_err", mem_err, 1'b0);
        tick();
        clear_inputs();
        nRST = 1'b1;
        #1;
        check("mr_idle_stall", stall, 1'b0);
        ex_dREN = 1; dmem_bus.dhit = 1'b1;
        #1;
        check("mr_idle_hit", stall, 1'b0);
        tick();
        clear_inputs();
        tick();

        // Halt: sticky, stalls forever, blocks memory, redirect and write-back.
        ex_halt = 1;
        #1;
        check("ht_first_stall", stall, 1'b0);
        tick();
        check("ht_wb_halt", wb_halt, 1'b1);
        check("ht_stall", stall, 1'b1);
        ex_halt = 0; ex_dREN = 1; ex_regWEN = 1; ex_Jump = 1; ex_jaddr = 32'h400;
        dmem_bus.dhit = 1'b1;
        #1;
        check("ht_dmemREN", dmem_bus.dmemREN, 1'b0);
        check("ht_redirect", redirect, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ht_wb_regWEN", wb_regWEN, 1'b0);
            check("ht_wb_halt_hold", wb_halt, 1'b1);
            check("ht_stall_hold", stall, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
